// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubble insertion, operand forwarding and freeze snapshots.
// Optional load-use interlock is built only when IDEX_LOADUSE_EN is defined.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [CTRLW-1:0] id_ctrl,
  input  logic [1:0]       bp_rs_sel,
  input  logic [1:0]       bp_rt_sel,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  output logic             id_stall,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [4:0]       ex_rs_addr,
  output logic [4:0]       ex_rt_addr,
  output logic [4:0]       ex_rd_addr,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_op_a,
  output logic [WIDTH-1:0] ex_op_b
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [4:0]       rd_addr;
    logic [CTRLW-1:0] ctrl;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
  } ex_regs_t;

  ex_regs_t         ex_d, ex_q;
  logic             captured_d, captured_q;
  logic [WIDTH-1:0] snap_a_d, snap_a_q;
  logic [WIDTH-1:0] snap_b_d, snap_b_q;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // Select 11 is unused by the bypass controller and falls back to the register copy.
  function automatic logic [WIDTH-1:0] bypass_mux(input logic [1:0]       sel,
                                                  input logic [WIDTH-1:0] reg_val,
                                                  input logic [WIDTH-1:0] mem_val,
                                                  input logic [WIDTH-1:0] wb_val);
    case (sel)
      2'b01:   return mem_val;
      2'b10:   return wb_val;
      default: return reg_val;
    endcase
  endfunction

  // Forwarded operands; a captured snapshot overrides the live bypass paths.
  always_comb begin
    fwd_a = bypass_mux(bp_rs_sel, ex_q.rs_data, mem_result, wb_result);
    fwd_b = bypass_mux(bp_rt_sel, ex_q.rt_data, mem_result, wb_result);
    if (captured_q) begin
      ex_op_a = snap_a_q;
      ex_op_b = snap_b_q;
    end else begin
      ex_op_a = fwd_a;
      ex_op_b = fwd_b;
    end
  end

`ifdef IDEX_LOADUSE_EN
  // A flush squashes the dependent instruction, so no stall is needed alongside it.
  always_comb begin
    id_stall = ex_q.valid & ex_q.memread & (ex_q.rd_addr != 5'd0) & id_valid & ~flush &
               ((ex_q.rd_addr == id_rs_addr) | (ex_q.rd_addr == id_rt_addr));
  end
`else
  assign id_stall = 1'b0;
`endif

  // Next-state: hold and snapshot on freeze, bubble on flush/stall/invalid, else load ID.
  always_comb begin
    ex_d       = ex_q;
    captured_d = captured_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    if (freeze) begin
      if (!captured_q) begin
        snap_a_d   = fwd_a;
        snap_b_d   = fwd_b;
        captured_d = 1'b1;
      end else begin
        captured_d = 1'b1;
      end
    end else begin
      captured_d = 1'b0;
      if (flush || id_stall || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        ex_d.rs_addr  = id_rs_addr;
        ex_d.rt_addr  = id_rt_addr;
        ex_d.rd_addr  = id_rd_addr;
        ex_d.ctrl     = id_ctrl;
        ex_d.imm      = id_imm;
        ex_d.rs_data  = id_rs_data;
        ex_d.rt_data  = id_rt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      captured_q <= 1'b0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
    end else begin
      ex_q       <= ex_d;
      captured_q <= captured_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_rs_addr  = ex_q.rs_addr;
  assign ex_rt_addr  = ex_q.rt_addr;
  assign ex_rd_addr  = ex_q.rd_addr;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_imm      = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then randomized traffic
// against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, freeze, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_regwrite, id_memread;
  logic [7:0]  id_ctrl;
  logic [1:0]  bp_rs_sel, bp_rt_sel;
  logic [31:0] mem_result, wb_result;
  logic        id_stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_imm, ex_op_a, ex_op_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .CTRLW(8)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .bp_rs_sel(bp_rs_sel), .bp_rt_sel(bp_rt_sel),
    .mem_result(mem_result), .wb_result(wb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
  );

  // Model of what instruction currently sits in EX, plus the freeze snapshot.
  typedef struct {
    bit        valid, regwrite, memread;
    bit [4:0]  rs, rt, rd;
    bit [7:0]  ctrl;
    bit [31:0] imm, a, b;
  } exp_t;

  exp_t      m;
  bit        mc;
  bit [31:0] snap_a, snap_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] model_op(input bit [1:0] sel, input bit [31:0] regv,
                                         input bit [31:0] snap);
    if (mc) return snap;
    if (sel == 2'd1) return mem_result;
    if (sel == 2'd2) return wb_result;
    return regv;
  endfunction

  function automatic bit model_stall();
`ifdef IDEX_LOADUSE_EN
    return m.valid && m.memread && m.rd != 5'd0 && id_valid && !flush &&
           (m.rd == id_rs_addr || m.rd == id_rt_addr);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_regs();
    check("ex_valid",    {63'd0, ex_valid},    {63'd0, m.valid});
    check("ex_regwrite", {63'd0, ex_regwrite}, {63'd0, m.regwrite});
    check("ex_memread",  {63'd0, ex_memread},  {63'd0, m.memread});
    check("ex_rs_addr",  {59'd0, ex_rs_addr},  {59'd0, m.rs});
    check("ex_rt_addr",  {59'd0, ex_rt_addr},  {59'd0, m.rt});
    check("ex_rd_addr",  {59'd0, ex_rd_addr},  {59'd0, m.rd});
    check("ex_ctrl",     {56'd0, ex_ctrl},     {56'd0, m.ctrl});
    check("ex_imm",      {32'd0, ex_imm},      {32'd0, m.imm});
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit        stall_e;
    bit [31:0] op_a_e, op_b_e;
    #1;
    stall_e = model_stall();
    op_a_e  = model_op(bp_rs_sel, m.a, snap_a);
    op_b_e  = model_op(bp_rt_sel, m.b, snap_b);
    check("id_stall", {63'd0, id_stall}, {63'd0, stall_e});
    if (m.valid || mc) begin
      check("ex_op_a", {32'd0, ex_op_a}, {32'd0, op_a_e});
      check("ex_op_b", {32'd0, ex_op_b}, {32'd0, op_b_e});
    end
    if (reset) begin
      m = '{default: 0}; mc = 1'b0; snap_a = 32'd0; snap_b = 32'd0;
    end else if (freeze) begin
      if (!mc) begin
        snap_a = op_a_e; snap_b = op_b_e; mc = 1'b1;
      end
    end else begin
      mc = 1'b0;
      if (flush || stall_e || !id_valid) begin
        m = '{default: 0};
      end else begin
        m.valid = 1'b1; m.regwrite = id_regwrite; m.memread = id_memread;
        m.rs = id_rs_addr; m.rt = id_rt_addr; m.rd = id_rd_addr;
        m.ctrl = id_ctrl; m.imm = id_imm; m.a = id_rs_data; m.b = id_rt_data;
      end
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] a, input bit [31:0] b, input bit mr);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = a; id_rt_data = b; id_memread = mr; id_regwrite = 1'b1;
    id_imm = a ^ 32'h0000_F0F0; id_ctrl = rd ^ 8'hA5;
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    id_regwrite = 1'b0;
    bp_rs_sel = 2'b00; bp_rt_sel = 2'b00; mem_result = 32'd0; wb_result = 32'd0;
    m = '{default: 0}; mc = 1'b0; snap_a = 32'd0; snap_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check("reset_op_a", {32'd0, ex_op_a}, 64'd0);
    check("reset_stall", {63'd0, id_stall}, 64'd0);
    reset = 1'b0;

    // Plain register path
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b0);
    tick();
    check("basic_op_a", {32'd0, ex_op_a}, 64'h11);
    check("basic_op_b", {32'd0, ex_op_b}, 64'h22);
    check("basic_valid", {63'd0, ex_valid}, 64'd1);

    // MEM and WB bypass in the same cycle; ID now holds a load to r5
    bp_rs_sel = 2'b01; mem_result = 32'hAA; bp_rt_sel = 2'b10; wb_result = 32'hBB;
    #1;
    check("fwd_mem_op_a", {32'd0, ex_op_a}, 64'hAA);
    check("fwd_wb_op_b", {32'd0, ex_op_b}, 64'hBB);
    set_id(1'b1, 5'd6, 5'd7, 5'd5, 32'h66, 32'h77, 1'b1);
    bp_rs_sel = 2'b00; bp_rt_sel = 2'b00;
    tick();

    // Load-use on r5
    set_id(1'b1, 5'd5, 5'd9, 5'd10, 32'h55, 32'h99, 1'b0);
    #1;
`ifdef IDEX_LOADUSE_EN
    check("loaduse_stall", {63'd0, id_stall}, 64'd1);
    tick();
    check("loaduse_bubble_valid", {63'd0, ex_valid}, 64'd0);
    check("loaduse_bubble_rd", {59'd0, ex_rd_addr}, 64'd0);
    check("loaduse_stall_once", {63'd0, id_stall}, 64'd0);
    tick();
`else
    check("loaduse_no_stall", {63'd0, id_stall}, 64'd0);
    tick();
`endif
    check("dependent_in_ex_rd", {59'd0, ex_rd_addr}, 64'd10);
    check("dependent_in_ex_valid", {63'd0, ex_valid}, 64'd1);

    // Load to r0 never interlocks
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 32'h3, 32'h4, 1'b0);
    #1;
    check("rd0_no_stall", {63'd0, id_stall}, 64'd0);
    tick();

    // Flush together with a hazard: bubble, no stall
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 5'd8, 32'h3, 32'h4, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_hazard_stall", {63'd0, id_stall}, 64'd0);
    tick();
    check("flush_bubble_valid", {63'd0, ex_valid}, 64'd0);
    flush = 1'b0;

    // Freeze snapshots the WB-forwarded operand
    set_id(1'b1, 5'd3, 5'd4, 5'd11, 32'h1234, 32'h5678, 1'b0);
    tick();
    bp_rs_sel = 2'b10; wb_result = 32'h55; freeze = 1'b1;
    tick();
    wb_result = 32'h99;
    tick();
    tick();
    check("freeze_hold_op_a", {32'd0, ex_op_a}, 64'h55);
    check("freeze_hold_rd", {59'd0, ex_rd_addr}, 64'd11);
    freeze = 1'b0;
    set_id(1'b1, 5'd6, 5'd7, 5'd12, 32'h42, 32'h43, 1'b0);
    tick();
    check("unfreeze_loads_rd", {59'd0, ex_rd_addr}, 64'd12);
    check("unfreeze_live_op_a", {32'd0, ex_op_a}, 64'h99);

    // Reset while frozen with a captured snapshot
    freeze = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("reset_in_freeze_valid", {63'd0, ex_valid}, 64'd0);
    check("reset_in_freeze_rd", {59'd0, ex_rd_addr}, 64'd0);
    reset = 1'b0; freeze = 1'b0;
    bp_rs_sel = 2'b01; mem_result = 32'h77;
    #1;
    check("reset_clears_captured", {32'd0, ex_op_a}, 64'h77);

    // Randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      freeze = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 2) == 0);
      id_regwrite = 1'($urandom_range(0, 1));
      id_ctrl = 8'($urandom);
      bp_rs_sel = 2'($urandom_range(0, 3));
      bp_rt_sel = 2'($urandom_range(0, 3));
      mem_result = $urandom;
      wb_result = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the MIPS mini-CPU.
- Captures decoded instruction fields and register-file operands at the end of ID.
- Drives `ex_rs_addr`/`ex_rt_addr` to the bypass controller and applies its select codes to produce the forwarded EX operands.
- Inserts bubbles for load-use hazards and branch flushes.
- Holds and snapshots forwarded operands across a pipeline freeze.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `CTRLW`, 8, width of the opaque EX/MEM/WB control bundle

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `freeze`  in  1  global stall (e.g. memory busy); ID/EX holds
- `flush`  in  1  branch taken; squash the ID instruction
- `id_valid`  in  1  ID holds a real instruction
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr`  in  5 each  source/destination specifiers
- `id_rs_data`, `id_rt_data`  in  WIDTH each  register-file read data
- `id_imm`  in  WIDTH  sign/zero-extended immediate
- `id_regwrite`, `id_memread`  in  1 each  writes a register / is a load
- `id_ctrl`  in  CTRLW  remaining control bundle, passed through
- `bp_rs_sel`, `bp_rt_sel`  in  2 each  bypass selects (00 reg, 01 stage3/MEM, 10 stage4/WB, 11 treated as reg)
- `mem_result`, `wb_result`  in  WIDTH each  MEM and WB stage result values
- `id_stall`  out  1  hold PC and IF/ID this cycle
- `ex_valid`, `ex_regwrite`, `ex_memread`  out  1 each
- `ex_rs_addr`, `ex_rt_addr`, `ex_rd_addr`  out  5 each
- `ex_ctrl`  out  CTRLW
- `ex_imm`, `ex_op_a`, `ex_op_b`  out  WIDTH each  `ex_op_a`/`ex_op_b` are the forwarded rs/rt operands

## Operation
At each rising edge of `clk`, the first matching case below applies.
- **`reset`:** all registered outputs are 0, `captured` is 0 and the snapshot registers are 0.
- **`freeze`:** every ID/EX register holds. If `captured` is 0, the current `ex_op_a`/`ex_op_b` are written to the snapshot registers and `captured` is set to 1. `flush` is ignored; upstream keeps it asserted until `freeze` drops.
- **`flush` or `id_stall`:** load a bubble. `ex_valid`, `ex_regwrite`, `ex_memread` and `ex_ctrl` are 0; `ex_rs_addr`, `ex_rt_addr` and `ex_rd_addr` are 0, so no bypass match occurs; `ex_imm` is 0.
- **Otherwise:** load all ID fields. `ex_valid` is loaded from `id_valid`. When `id_valid` is 0, the fields are loaded as a bubble. `captured` is cleared.

Operand forwarding is combinational within EX:
- While `captured` is 1, `ex_op_a`/`ex_op_b` are the snapshot values.
- Otherwise each operand is selected by its bypass select: 00 or 11 gives the registered `id_rs_data`/`id_rt_data` copy; 01 gives `mem_result`; 10 gives `wb_result`.

Load-use interlock (combinational):
- `id_stall` = `ex_valid` & `ex_memread` & (`ex_rd_addr` != 0) & `id_valid` & !`flush` & (`ex_rd_addr` == `id_rs_addr` | `ex_rd_addr` == `id_rt_addr`).
- `id_stall` is asserted for exactly one cycle per hazard, because the bubble clears `ex_memread`.
- It is not qualified by `freeze`; upstream already holds under `freeze`.

Only addresses are compared and widths are fixed, so there is no arithmetic in this block.

## Timing
- ID to EX latency is 1 cycle. Forwarded operands are valid in the same cycle the bypass selects are valid.
- Load-use penalty is 1 bubble. The dependent instruction enters EX when the load reaches WB and is served by select 10.
- Flush costs 1 bubble. A flush asserted together with a hazard yields one bubble and no stall.
- Freeze mid-operation: on the first frozen edge the operands are snapshotted. Later WB retirement does not alter `ex_op_a`/`ex_op_b`. The first unfrozen edge advances normally.
- Reset asserted during freeze or stall clears everything at that edge.

## Configuration
`IDEX_LOADUSE_EN`:
- **Defined:** the interlock logic is as described above.
- **Undefined:** `id_stall` is tied to 0 and no interlock logic is built. The compiler/toolchain guarantees a load delay slot, and all other behaviour is unchanged.

## Test plan
- Reset, then `id_valid`=1, `id_rs_data`=0x11, `id_rt_data`=0x22, selects 00 -> next cycle `ex_op_a`=0x11, `ex_op_b`=0x22, `ex_valid`=1.
- With `bp_rs_sel`=01, `mem_result`=0xAA and `bp_rt_sel`=10, `wb_result`=0xBB -> `ex_op_a`=0xAA, `ex_op_b`=0xBB in the same cycle.
- EX holds a load with `ex_rd_addr`=5 and ID reads rs=5 -> `id_stall`=1 for one cycle. Next cycle `ex_valid`=0 and `ex_rd_addr`=0; the cycle after, the dependent instruction is in EX. With the macro undefined, `id_stall` stays 0. Repeat with rd=0 -> no stall.
- Assert `flush` while the same hazard condition exists -> `id_stall`=0 and a bubble is loaded.
- Select 10 with `wb_result`=0x55, assert `freeze` for 3 cycles, change `wb_result` to 0x99 -> `ex_op_a` stays 0x55. Release `freeze` -> the next ID instruction loads.
- Assert `reset` during `freeze` with `captured`=1 -> all outputs are 0 next cycle and `captured` is 0.
